// File: rtl/ram_copy_engine.sv
// -----------------------------------------------------------------------------
// ram_copy_engine
//
// Moves a block of words from a source RAM (RAM_X) to a destination RAM
// (RAM_Y) at one word per clock. Three transfer kinds:
//   copy     : RAM_Y[dst+k] = RAM_X[src+k]
//   reverse  : RAM_Y[dst-k] = RAM_X[src-k]
//   fill     : RAM_Y[dst+k] = fill_value (RAM_X untouched)
// All address arithmetic wraps modulo 2^ADDR_WIDTH.
//
// RAM_X has a one-cycle read latency, so a copy spends one PRIME cycle
// issuing the first read, STREAM cycles that overlap read k+1 with write k,
// and a DRAIN cycle for the final write. A fill has no read latency and
// writes from the first cycle.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, mode                launch a transfer (sampled only when idle)
//   src_base, dst_base         first source / destination address
//   length                     word count (0 = no-op, 2^ADDR_WIDTH = whole RAM)
//   fill_value                 word written in fill mode
//   abort                      terminate the active transfer
//   RAM_X_*                    source RAM port (read only)
//   RAM_Y_*                    destination RAM port (write only)
//   busy                       transfer in progress
//   done / aborted             one-cycle completion pulses
// -----------------------------------------------------------------------------
module ram_copy_engine #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [ADDR_WIDTH-1:0]   src_base,
  input  logic [ADDR_WIDTH-1:0]   dst_base,
  input  logic [ADDR_WIDTH:0]     length,
  input  logic [DATA_WIDTH-1:0]   fill_value,
  input  logic                    abort,
  input  logic [DATA_WIDTH-1:0]   RAM_X_Do,
  output logic                    RAM_X_EN,
  output logic [ADDR_WIDTH-1:0]   RAM_X_A,
  output logic [DATA_WIDTH/8-1:0] RAM_X_WE,
  output logic                    RAM_Y_EN,
  output logic [ADDR_WIDTH-1:0]   RAM_Y_A,
  output logic [DATA_WIDTH/8-1:0] RAM_Y_WE,
  output logic [DATA_WIDTH-1:0]   RAM_Y_Di,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted
);

  localparam int WE_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  // Registered state; the RAM port outputs are driven straight from these.
  state_t                  r_state;
  logic                    r_rev;
  logic                    r_fill;
  logic [DATA_WIDTH-1:0]   r_fill_value;
  logic                    r_x_en;
  logic [ADDR_WIDTH-1:0]   r_x_a;
  logic                    r_y_en;
  logic [ADDR_WIDTH-1:0]   r_y_a;
  logic [ADDR_WIDTH-1:0]   r_wr_ptr;   // address of the next write to issue
  logic [ADDR_WIDTH:0]     r_rem;      // issues still to come after this cycle
  logic                    r_done;
  logic                    r_aborted;

  state_t                  w_state_nxt;
  logic                    w_rev_nxt;
  logic                    w_fill_nxt;
  logic [DATA_WIDTH-1:0]   w_fill_value_nxt;
  logic                    w_x_en_nxt;
  logic [ADDR_WIDTH-1:0]   w_x_a_nxt;
  logic                    w_y_en_nxt;
  logic [ADDR_WIDTH-1:0]   w_y_a_nxt;
  logic [ADDR_WIDTH-1:0]   w_wr_ptr_nxt;
  logic [ADDR_WIDTH:0]     w_rem_nxt;
  logic                    w_done_nxt;
  logic                    w_aborted_nxt;

  // Direction-aware address steps; fill never sets r_rev.
  logic [ADDR_WIDTH-1:0]   w_x_a_step;
  logic [ADDR_WIDTH-1:0]   w_wr_ptr_step;

  assign w_x_a_step    = r_rev ? r_x_a - 1'b1    : r_x_a + 1'b1;
  assign w_wr_ptr_step = r_rev ? r_wr_ptr - 1'b1 : r_wr_ptr + 1'b1;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned; an unassigned path would infer a latch.
    w_state_nxt      = r_state;
    w_rev_nxt        = r_rev;
    w_fill_nxt       = r_fill;
    w_fill_value_nxt = r_fill_value;
    w_x_en_nxt       = 1'b0;
    w_x_a_nxt        = r_x_a;
    w_y_en_nxt       = 1'b0;
    w_y_a_nxt        = r_y_a;
    w_wr_ptr_nxt     = r_wr_ptr;
    w_rem_nxt        = r_rem;
    w_done_nxt       = 1'b0;
    w_aborted_nxt    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          // Latch everything the transfer needs so later input changes
          // cannot disturb it.
          w_rev_nxt        = (mode == 2'b01);
          w_fill_nxt       = (mode == 2'b10);
          w_fill_value_nxt = fill_value;
          if (length == '0) begin
            w_done_nxt = 1'b1;
          end else if (mode == 2'b10) begin
            // Fill: first write goes out immediately, no read latency.
            w_y_en_nxt   = 1'b1;
            w_y_a_nxt    = dst_base;
            w_wr_ptr_nxt = dst_base + 1'b1;
            w_rem_nxt    = length - 1'b1;
            w_state_nxt  = (length == LEN_ONE) ? DRAIN : STREAM;
          end else begin
            // Copy / reverse (mode 11 behaves as copy): issue read 0.
            w_x_en_nxt   = 1'b1;
            w_x_a_nxt    = src_base;
            w_wr_ptr_nxt = dst_base;
            w_rem_nxt    = length - 1'b1;
            w_state_nxt  = PRIME;
          end
        end
      end

      PRIME, STREAM: begin
        // Both kinds write in the next cycle: a fill always, a copy because
        // the read issued this cycle returns data next cycle.
        w_y_en_nxt   = 1'b1;
        w_y_a_nxt    = r_wr_ptr;
        w_wr_ptr_nxt = w_wr_ptr_step;
        if (r_fill) begin
          w_rem_nxt   = r_rem - 1'b1;
          w_state_nxt = (r_rem == LEN_ONE) ? DRAIN : STREAM;
        end else if (r_rem != '0) begin
          w_x_en_nxt  = 1'b1;
          w_x_a_nxt   = w_x_a_step;
          w_rem_nxt   = r_rem - 1'b1;
          w_state_nxt = STREAM;
        end else begin
          w_state_nxt = DRAIN;
        end
      end

      DRAIN: begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
      end

      default: w_state_nxt = IDLE;
    endcase

    // Abort overrides whatever was planned for the next cycle; the access
    // presented in the current cycle still completes at this edge.
    if (r_state != IDLE && abort) begin
      w_state_nxt   = IDLE;
      w_x_en_nxt    = 1'b0;
      w_y_en_nxt    = 1'b0;
      w_done_nxt    = 1'b0;
      w_aborted_nxt = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rev        <= 1'b0;
      r_fill       <= 1'b0;
      r_fill_value <= '0;
      r_x_en       <= 1'b0;
      r_x_a        <= '0;
      r_y_en       <= 1'b0;
      r_y_a        <= '0;
      r_wr_ptr     <= '0;
      r_rem        <= '0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rev        <= w_rev_nxt;
      r_fill       <= w_fill_nxt;
      r_fill_value <= w_fill_value_nxt;
      r_x_en       <= w_x_en_nxt;
      r_x_a        <= w_x_a_nxt;
      r_y_en       <= w_y_en_nxt;
      r_y_a        <= w_y_a_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rem        <= w_rem_nxt;
      r_done       <= w_done_nxt;
      r_aborted    <= w_aborted_nxt;
    end
  end

  assign RAM_X_EN = r_x_en;
  assign RAM_X_A  = r_x_a;
  assign RAM_X_WE = '0;
  assign RAM_Y_EN = r_y_en;
  assign RAM_Y_A  = r_y_a;
  assign RAM_Y_WE = {WE_W{r_y_en}};
  // Copy data flows straight from the RAM_X read port into the write port;
  // the bus is held at zero whenever no write is presented.
  assign RAM_Y_Di = r_y_en ? (r_fill ? r_fill_value : RAM_X_Do) : '0;
  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign aborted  = r_aborted;

endmodule

// File: tb/tb_ram_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_ram_copy_engine
//
// Bench for ram_copy_engine with behavioural RAM_X / RAM_Y models. A monitor
// logs every RAM access, busy cycle and completion pulse on the falling edge.
// A timeline model builds the expected logs from the transfer rules (read k
// in cycle T+1+k, copy write k in T+2+k, fill write k in T+1+k, completion
// the cycle after the last write, abort truncation), and each scenario
// compares the logs against it. Cycle T+j is the clock period in which the
// bench cycle counter equals t0+j, t0 being the counter value while start
// is presented.
// -----------------------------------------------------------------------------
module tb_ram_copy_engine;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int WEW   = DW / 8;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    int          cyc;
    logic [AW-1:0] a;
  } rd_t;

  typedef struct packed {
    int            cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [WEW-1:0] we;
  } wr_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [1:0]     mode;
  logic [AW-1:0]  src_base;
  logic [AW-1:0]  dst_base;
  logic [AW:0]    length;
  logic [DW-1:0]  fill_value;
  logic           abort;
  logic [DW-1:0]  ram_x_do;
  logic           x_en;
  logic [AW-1:0]  x_a;
  logic [WEW-1:0] x_we;
  logic           y_en;
  logic [AW-1:0]  y_a;
  logic [WEW-1:0] y_we;
  logic [DW-1:0]  y_di;
  logic           busy;
  logic           done;
  logic           aborted;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int x_we_bad = 0;

  logic [DW-1:0] mem_x [DEPTH];
  logic [DW-1:0] mem_y [DEPTH];

  rd_t rd_log[$];
  rd_t exp_rd[$];
  wr_t wr_log[$];
  wr_t exp_wr[$];
  int  done_log[$];
  int  exp_done[$];
  int  abort_log[$];
  int  exp_abort[$];
  int  busy_log[$];
  int  exp_busy[$];

  always #5 clk = ~clk;

  ram_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .src_base   (src_base),
    .dst_base   (dst_base),
    .length     (length),
    .fill_value (fill_value),
    .abort      (abort),
    .RAM_X_Do   (ram_x_do),
    .RAM_X_EN   (x_en),
    .RAM_X_A    (x_a),
    .RAM_X_WE   (x_we),
    .RAM_Y_EN   (y_en),
    .RAM_Y_A    (y_a),
    .RAM_Y_WE   (y_we),
    .RAM_Y_Di   (y_di),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Source RAM: registered read, data one cycle after the address.
  always @(posedge clk) if (x_en) ram_x_do <= mem_x[x_a];

  // Destination RAM with byte write enables.
  always @(posedge clk) begin
    if (y_en) begin
      for (int b = 0; b < WEW; b++) begin
        if (y_we[b]) mem_y[y_a][8*b +: 8] <= y_di[8*b +: 8];
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (x_en) rd_log.push_back('{cyc, x_a});
      if (y_en || y_we != '0) wr_log.push_back('{cyc, y_a, y_di, y_we});
      if (done) done_log.push_back(cyc);
      if (aborted) abort_log.push_back(cyc);
      if (busy) busy_log.push_back(cyc);
      if (x_we != '0) x_we_bad++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wr_log.delete();
    done_log.delete();
    abort_log.delete();
    busy_log.delete();
    x_we_bad = 0;
  endtask

  // Timeline model. abort_cyc < 0 means no abort reaches the transfer.
  task automatic build_model(input logic [1:0] m, input logic [AW-1:0] src,
                             input logic [AW-1:0] dst, input int len,
                             input logic [DW-1:0] fv, input int t0,
                             input int abort_cyc);
    bit            fill;
    bit            rev;
    int            last;
    int            wc;
    int            busy_end;
    logic [AW-1:0] sa;
    logic [AW-1:0] da;
    fill = (m == 2'b10);
    rev  = (m == 2'b01);
    exp_rd.delete();
    exp_wr.delete();
    exp_done.delete();
    exp_abort.delete();
    exp_busy.delete();
    if (len == 0) begin
      exp_done.push_back(t0 + 1);
      return;
    end
    last = fill ? t0 + len : t0 + len + 1;
    for (int k = 0; k < len; k++) begin
      sa = rev ? AW'(int'(src) - k) : AW'(int'(src) + k);
      da = rev ? AW'(int'(dst) - k) : AW'(int'(dst) + k);
      wc = fill ? t0 + 1 + k : t0 + 2 + k;
      if (!fill && (abort_cyc < 0 || t0 + 1 + k <= abort_cyc))
        exp_rd.push_back('{t0 + 1 + k, sa});
      if (abort_cyc < 0 || wc <= abort_cyc)
        exp_wr.push_back('{wc, da, (fill ? fv : mem_x[sa]), {WEW{1'b1}}});
    end
    busy_end = (abort_cyc < 0) ? last : abort_cyc;
    for (int c = t0 + 1; c <= busy_end; c++) exp_busy.push_back(c);
    if (abort_cyc < 0) exp_done.push_back(last + 1);
    else               exp_abort.push_back(abort_cyc + 1);
  endtask

  // Launches one transfer, optionally aborts it (abort_at = j asserts abort
  // during cycle T+j; 0 asserts it together with start) or pokes start while
  // busy, waits for completion, then compares the logs against the model.
  task automatic run_check(input string name, input logic [1:0] m,
                           input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input int len, input logic [DW-1:0] fv,
                           input int abort_at, input bit poke,
                           input bit immediate, input int tail);
    int t0;
    int j;
    bit timed_out;
    bit bad;
    if (!immediate) step();
    mode       = m;
    src_base   = src;
    dst_base   = dst;
    length     = len[AW:0];
    fill_value = fv;
    start      = 1'b1;
    abort      = (abort_at == 0);
    t0 = cyc;
    clear_logs();
    build_model(m, src, dst, len, fv, t0, (abort_at > 0) ? t0 + abort_at : -1);
    step();
    // Scramble the inputs: the transfer must run from its latched copies.
    mode       = 2'($urandom);
    src_base   = AW'($urandom);
    dst_base   = AW'($urandom);
    length     = (AW+1)'($urandom);
    fill_value = $urandom;
    j = 1;
    timed_out = 1'b0;
    forever begin
      if (done || aborted) break;
      if (j > len + 12) begin
        timed_out = 1'b1;
        break;
      end
      abort = (abort_at == j);
      start = poke && (j == 2) && busy;
      step();
      j++;
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (tail) step();

    checks++;
    if (timed_out) begin
      failures++;
      $display("FAIL %s completion: no done/aborted within %0d cycles", name, len + 12);
    end

    checks++;
    bad = 1'b0;
    if (rd_log.size() != exp_rd.size()) begin
      bad = 1'b1;
      $display("FAIL %s reads: got %0d reads, want %0d", name, rd_log.size(), exp_rd.size());
    end else begin
      for (int i = 0; i < exp_rd.size() && !bad; i++) begin
        if (rd_log[i] !== exp_rd[i]) begin
          bad = 1'b1;
          $display("FAIL %s read[%0d]: got T+%0d a=%h, want T+%0d a=%h", name, i,
                   rd_log[i].cyc - t0, rd_log[i].a, exp_rd[i].cyc - t0, exp_rd[i].a);
        end
      end
    end
    if (bad) failures++;

    checks++;
    bad = 1'b0;
    if (wr_log.size() != exp_wr.size()) begin
      bad = 1'b1;
      $display("FAIL %s writes: got %0d writes, want %0d", name, wr_log.size(), exp_wr.size());
    end else begin
      for (int i = 0; i < exp_wr.size() && !bad; i++) begin
        if (wr_log[i] !== exp_wr[i]) begin
          bad = 1'b1;
          $display("FAIL %s write[%0d]: got T+%0d a=%h d=%h we=%h, want T+%0d a=%h d=%h we=%h",
                   name, i, wr_log[i].cyc - t0, wr_log[i].a, wr_log[i].d, wr_log[i].we,
                   exp_wr[i].cyc - t0, exp_wr[i].a, exp_wr[i].d, exp_wr[i].we);
        end
      end
    end
    if (bad) failures++;

    checks++;
    if (done_log != exp_done || abort_log != exp_abort) begin
      failures++;
      $display("FAIL %s pulses: got done=%p aborted=%p, want done=%p aborted=%p (absolute cycles, T=%0d)",
               name, done_log, abort_log, exp_done, exp_abort, t0);
    end

    checks++;
    bad = 1'b0;
    if (busy_log.size() != exp_busy.size()) bad = 1'b1;
    else for (int i = 0; i < exp_busy.size(); i++) if (busy_log[i] != exp_busy[i]) bad = 1'b1;
    if (bad) begin
      failures++;
      $display("FAIL %s busy: got %0d busy cycles, want %0d (T+1..T+%0d)", name,
               busy_log.size(), exp_busy.size(), exp_busy.size());
    end

    checks++;
    if (x_we_bad != 0) begin
      failures++;
      $display("FAIL %s RAM_X_WE: got %0d cycles nonzero, want 0", name, x_we_bad);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({busy, done, aborted, x_en, y_en} !== 5'b0) begin
      failures++;
      $display("FAIL %s control: got busy/done/aborted/xen/yen=%b, want 00000", name,
               {busy, done, aborted, x_en, y_en});
    end
    checks++;
    if ({x_we, y_we} !== '0) begin
      failures++;
      $display("FAIL %s write enables: got x_we=%h y_we=%h, want 0", name, x_we, y_we);
    end
    checks++;
    if ({x_a, y_a, y_di} !== '0) begin
      failures++;
      $display("FAIL %s buses: got x_a=%h y_a=%h y_di=%h, want 0", name, x_a, y_a, y_di);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = '0;
    src_base = '0; dst_base = '0; length = '0; fill_value = '0;
    #12;
    check_outputs_zero("reset");
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_copy();
    run_check("copy", 2'b00, 9'h010, 9'h100, 4, $urandom, -1, 1'b0, 1'b0, 2);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_y[9'h100 + i] !== mem_x[9'h010 + i]) begin
        failures++;
        $display("FAIL copy RAM_Y[%h]: got %h, want %h", 9'h100 + i, mem_y[9'h100 + i], mem_x[9'h010 + i]);
      end
    end
  endtask

  task automatic test_reverse_wrap();
    logic [AW-1:0] s;
    logic [AW-1:0] d;
    run_check("reverse_wrap", 2'b01, 9'h001, 9'h1FF, 3, $urandom, -1, 1'b0, 1'b0, 2);
    for (int i = 0; i < 3; i++) begin
      s = AW'(1 - i);
      d = AW'(511 - i);
      checks++;
      if (mem_y[d] !== mem_x[s]) begin
        failures++;
        $display("FAIL reverse_wrap RAM_Y[%h]: got %h, want %h", d, mem_y[d], mem_x[s]);
      end
    end
  endtask

  task automatic test_fill();
    logic [AW-1:0] d;
    run_check("fill", 2'b10, AW'($urandom), 9'h1FE, 4, 32'hDEADBEEF, -1, 1'b0, 1'b0, 2);
    for (int i = 0; i < 4; i++) begin
      d = AW'(9'h1FE + i);
      checks++;
      if (mem_y[d] !== 32'hDEADBEEF) begin
        failures++;
        $display("FAIL fill RAM_Y[%h]: got %h, want deadbeef", d, mem_y[d]);
      end
    end
  endtask

  task automatic test_full_and_zero();
    logic [AW-1:0] s;
    logic [AW-1:0] d;
    int bad;
    s = AW'($urandom);
    d = AW'($urandom);
    run_check("full_ram", 2'b00, s, d, DEPTH, $urandom, -1, 1'b0, 1'b0, 2);
    bad = 0;
    for (int k = 0; k < DEPTH; k++)
      if (mem_y[AW'(int'(d) + k)] !== mem_x[AW'(int'(s) + k)]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL full_ram contents: got %0d wrong words, want 0", bad);
    end
    run_check("zero_len", 2'b00, AW'($urandom), AW'($urandom), 0, $urandom, -1, 1'b0, 1'b0, 3);
  endtask

  task automatic test_abort();
    run_check("abort", 2'b00, 9'h020, 9'h080, 10, $urandom, 3, 1'b1, 1'b0, 4);
    // abort alone in IDLE must do nothing
    clear_logs();
    abort = 1'b1;
    step();
    abort = 1'b0;
    repeat (3) step();
    checks++;
    if (abort_log.size() != 0 || busy_log.size() != 0 || wr_log.size() != 0) begin
      failures++;
      $display("FAIL idle_abort: got %0d aborted pulses, %0d busy cycles, want 0",
               abort_log.size(), busy_log.size());
    end
    run_check("start_with_abort", 2'b11, AW'($urandom), AW'($urandom), 5, $urandom, 0, 1'b0, 1'b0, 2);
  endtask

  task automatic test_reset_mid();
    step();
    mode = 2'b00; src_base = 9'h040; dst_base = 9'h0C0; length = 10'd8;
    fill_value = $urandom;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    // now in cycle T+2 of the transfer
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid busy before reset: got %b, want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset_mid");
    step();
    rst_n = 1'b1;
    clear_logs();
    repeat (4) step();
    checks++;
    if (done_log.size() != 0 || abort_log.size() != 0 || rd_log.size() != 0 || wr_log.size() != 0) begin
      failures++;
      $display("FAIL reset_mid leftovers: got done=%0d aborted=%0d reads=%0d writes=%0d, want all 0",
               done_log.size(), abort_log.size(), rd_log.size(), wr_log.size());
    end
    run_check("after_reset", 2'b00, AW'($urandom), AW'($urandom), 6, $urandom, -1, 1'b0, 1'b0, 2);
  endtask

  task automatic test_back_to_back();
    run_check("b2b_copy", 2'b00, AW'($urandom), AW'($urandom), 6, $urandom, -1, 1'b0, 1'b0, 0);
    run_check("b2b_fill", 2'b10, AW'($urandom), AW'($urandom), 5, $urandom, -1, 1'b0, 1'b1, 0);
    run_check("b2b_rev",  2'b01, AW'($urandom), AW'($urandom), 4, $urandom, -1, 1'b0, 1'b1, 2);
  endtask

  task automatic test_random();
    logic [1:0] m;
    int len;
    int ab;
    for (int it = 0; it < 16; it++) begin
      m   = 2'($urandom_range(0, 3));
      len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
      ab  = -1;
      if (len > 0 && $urandom_range(0, 3) == 0)
        ab = int'($urandom_range(1, (m == 2'b10) ? len : len + 1));
      run_check($sformatf("random%0d", it), m, AW'($urandom), AW'($urandom), len,
                $urandom, ab, 1'($urandom_range(0, 1)), 1'b0, 1);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_x[i] = $urandom;
    test_reset();
    test_copy();
    test_reverse_wrap();
    test_fill();
    test_full_and_zero();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_copy_engine.md
RAM_COPY_ENGINE -- requirements
Module: ram_copy_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, RAM data width; WE width is DATA_WIDTH/8, and DATA_WIDTH SHALL be a multiple of 8.
REQ-003 SHALL have the following ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin transfer; sampled only in IDLE.
- mode  in  2  00 copy, 01 reverse copy, 10 fill, 11 reserved (treated as copy).
- src_base  in  ADDR_WIDTH  first RAM_X address.
- dst_base  in  ADDR_WIDTH  first RAM_Y address.
- length  in  ADDR_WIDTH+1  word count; 0 = no-op; 2^ADDR_WIDTH = whole RAM.
- fill_value  in  DATA_WIDTH  word written in fill mode.
- abort  in  1  terminate the active transfer.
- RAM_X_Do  in  DATA_WIDTH  RAM_X read data, valid 1 cycle after address.
- RAM_X_EN, RAM_X_A, RAM_X_WE  out  1/ADDR_WIDTH/DATA_WIDTH/8  source port; RAM_X_WE is constantly 0.
- RAM_Y_EN, RAM_Y_A, RAM_Y_WE, RAM_Y_Di  out  1/ADDR_WIDTH/DATA_WIDTH/8/DATA_WIDTH  destination port.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort completion.

Function
REQ-004 SHALL implement states IDLE, PRIME, STREAM, DRAIN.
REQ-005 At edge T in IDLE with start=1: SHALL latch mode, src_base, dst_base, length and fill_value; later input changes SHALL have no effect until the next start.
REQ-006 If length=0 at start: SHALL stay in IDLE, pulse done at T+1, and perform no RAM access.
REQ-007 Copy/reverse, length N>0:
- Read phase: busy=1 and RAM_X_EN=1 from T+1 through T+N; RAM_X_A = src_base+k (copy) or src_base-k (reverse) for read k.
- Write phase: write k occurs in cycle T+2+k with RAM_Y_WE all-ones, RAM_Y_A = dst_base+k (copy) or dst_base-k (reverse), RAM_Y_Di = RAM_X_Do.
- State sequence: PRIME at T+1, STREAM during overlap, DRAIN for the final write.
REQ-008 Fill, length N>0: SHALL make no RAM_X access; write k in cycle T+1+k with RAM_Y_Di=fill_value and RAM_Y_A=dst_base+k.
REQ-009 Throughput SHALL be one word per cycle with no bubbles.
REQ-010 All address arithmetic SHALL be modulo 2^ADDR_WIDTH (wrap-around, no error).
REQ-011 done SHALL pulse in the cycle after the last write; busy SHALL deassert in that same cycle.
REQ-012 RAM_Y_WE SHALL be 0 in every cycle without a scheduled write.
REQ-013 start while busy SHALL be ignored.
REQ-014 abort=1 sampled while busy:
- From the next cycle: RAM_X_EN=0, RAM_Y_EN=0, RAM_Y_WE=0, busy=0, state IDLE, aborted pulses for one cycle.
- A write scheduled in the abort-sampling cycle itself still completes.
- done SHALL NOT pulse.
REQ-015 abort in IDLE SHALL be ignored; abort and start together in IDLE: start wins.
REQ-016 Overlapping source/destination ranges need not be handled; copy is word-by-word in issue order.

Reset
REQ-017 While rst_n=0, independent of clk: state=IDLE; busy, done, aborted, RAM_X_EN, RAM_Y_EN = 0; RAM_X_WE, RAM_Y_WE = 0; RAM_X_A, RAM_Y_A, RAM_Y_Di = 0.
REQ-018 Reset asserted mid-transfer SHALL abandon the transfer with no done or aborted pulse; the first start after release SHALL behave per REQ-005.

Verification
REQ-019 The bench SHALL cover the following scenarios:
- Copy: src_base=0x010, dst_base=0x100, length=4, RAM_X[0x10..0x13]=A,B,C,D -> RAM_Y[0x100..0x103]=A,B,C,D; writes at T+2..T+5; done at T+6.
- Reverse copy wrap: src_base=0x001, dst_base=0x1FF, length=3 -> reads 0x001,0x000,0x1FF; writes 0x1FF,0x1FE,0x1FD.
- Fill: dst_base=0x1FE, length=4, fill_value=0xDEADBEEF -> RAM_Y at 0x1FE,0x1FF,0x000,0x001 = 0xDEADBEEF; no RAM_X_EN; done at T+5.
- Full-RAM copy with length=512: 512 writes, then done. length=0: done at T+1 with no EN.
- Abort at T+3 of a length-10 copy: only writes for k=0,1 occur; aborted pulses at T+4; no done; start during busy ignored.
- rst_n low at T+2 of a transfer: all outputs 0 immediately; a subsequent start runs correctly.
